// File: rtl/encod_pkg.sv
// Shared types, widths and popcount helper for the sequential 8-to-3 encoder.
// Pure package: no logic, no latency, no flow control.
package encod_pkg;

  localparam int VEC_W = 8;
  localparam int IDX_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < VEC_W; i++) begin
      cnt = cnt + CNT_W'(v[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/encod_prio8.sv
// Combinational 8:3 priority encoder returning the chosen index and the vector with it cleared.
// Zero latency; no flow control (pure function of vec).
module encod_prio8
  import encod_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic [VEC_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any,
  output logic [VEC_W-1:0] clr
);

  // Later loop iterations override earlier ones, so the walk direction picks the winner.
  always_comb begin
    idx = '0;
    any = |vec;
    if (MSB_FIRST) begin
      for (int i = 0; i < VEC_W; i++) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end else begin
      for (int i = VEC_W - 1; i >= 0; i--) begin
        if (vec[i]) idx = IDX_W'(i);
      end
    end
    clr = vec & ~(VEC_W'(1) << idx);
  end

endmodule

// File: rtl/encod_scan.sv
// Accepts a multi-hot vector and emits one set-bit index per beat; first beat the cycle after accept.
// Output stalls hold all state; a new vector is taken on the same edge as the last beat leaves.
module encod_scan
  import encod_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VEC_W-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_zero,
  output logic [CNT_W-1:0] out_total
);

  state_e           state_q, state_d;
  logic [VEC_W-1:0] rem_q, rem_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] total_q, total_d;

  logic             xfer;
  logic             accept;
  logic [VEC_W-1:0] enc_in;
  logic [IDX_W-1:0] enc_idx;
  logic             enc_any;
  logic [VEC_W-1:0] enc_clr;

  assign out_valid = (state_q == EMIT);
  assign xfer      = out_valid & out_ready;
  assign in_ready  = (state_q == IDLE) | (xfer & last_q);
  assign accept    = in_valid & in_ready;

  // One shared encoder: fresh vector on accept, otherwise the remaining bits.
  assign enc_in = accept ? in_vec : rem_q;

  encod_prio8 #(.MSB_FIRST(MSB_FIRST)) u_prio (
    .vec (enc_in),
    .idx (enc_idx),
    .any (enc_any),
    .clr (enc_clr)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    idx_d   = idx_q;
    last_d  = last_q;
    zero_d  = zero_q;
    total_d = total_q;
    if (accept) begin
      state_d = EMIT;
      rem_d   = enc_clr;
      idx_d   = enc_idx;
      total_d = popcount(in_vec);
      last_d  = (total_d <= CNT_W'(1));
      zero_d  = ~enc_any;
    end else if (xfer) begin
      if (!last_q) begin
        rem_d  = enc_clr;
        idx_d  = enc_idx;
        last_d = ~|enc_clr;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
      total_q <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      zero_q  <= zero_d;
      total_q <= total_d;
    end
  end

  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_zero  = zero_q;
  assign out_total = total_q;

endmodule

// File: tb/tb_encod_scan.sv
// Bench for encod_scan: LSB-first and MSB-first instances share stimulus and are checked every cycle
// against a queue-of-expected-beats model, plus a vector table and hand-written corner sequences.
module tb_encod_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_vec;
  logic       out_ready;

  logic [1:0] in_ready_w;
  logic [1:0] out_valid_w;
  logic [1:0] out_last_w;
  logic [1:0] out_zero_w;
  logic [2:0] out_idx_w   [2];
  logic [3:0] out_total_w [2];

  always #5 clk = ~clk;

  encod_scan #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_vec(in_vec),
    .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_idx(out_idx_w[0]),
    .out_last(out_last_w[0]), .out_zero(out_zero_w[0]), .out_total(out_total_w[0])
  );

  encod_scan #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_vec(in_vec),
    .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_idx(out_idx_w[1]),
    .out_last(out_last_w[1]), .out_zero(out_zero_w[1]), .out_total(out_total_w[1])
  );

  typedef struct {
    logic [2:0] idx;
    logic       last;
    logic       zero;
    logic [3:0] total;
  } beat_t;

  typedef struct {
    logic [7:0] vec;
    int         total;
    int         first_lsb;
    int         first_msb;
  } vec_rec_t;

  beat_t q0[$];
  beat_t q1[$];
  int    n_chk  = 0;
  int    n_pass = 0;
  bit    rst_flag = 1'b0;
  bit    acc = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected beats for one vector in the given scan order.
  task automatic push_vec(input logic [7:0] v);
    int    cnt;
    int    seen;
    int    i;
    beat_t b;
    cnt = 0;
    for (int j = 0; j < 8; j++) cnt += int'(v[j]);
    for (int k = 0; k < 2; k++) begin
      seen = 0;
      if (cnt == 0) begin
        b = '{3'd0, 1'b1, 1'b1, 4'd0};
        if (k == 0) q0.push_back(b); else q1.push_back(b);
      end else begin
        for (int j = 0; j < 8; j++) begin
          i = (k == 1) ? 7 - j : j;
          if (v[i]) begin
            seen++;
            b = '{3'(i), (seen == cnt), 1'b0, 4'(cnt)};
            if (k == 0) q0.push_back(b); else q1.push_back(b);
          end
        end
      end
    end
  endtask

  function automatic bit model_rdy();
    return (q0.size() == 0) || (out_ready && q0.size() == 1);
  endfunction

  task automatic model_step();
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      rst_flag = 1'b1;
      acc = 1'b0;
    end else begin
      acc = in_valid && model_rdy();
      if (out_ready && q0.size() > 0) begin
        void'(q0.pop_front());
        void'(q1.pop_front());
      end
      if (acc) begin
        push_vec(in_vec);
        rst_flag = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    beat_t b;
    string tag;
    for (int k = 0; k < 2; k++) begin
      tag = (k == 0) ? "lsb" : "msb";
      chk({tag, " in_ready"}, int'(in_ready_w[k]), int'(model_rdy()));
      chk({tag, " out_valid"}, int'(out_valid_w[k]), int'(q0.size() > 0));
      if (q0.size() > 0) begin
        b = (k == 0) ? q0[0] : q1[0];
        chk({tag, " out_idx"},   int'(out_idx_w[k]),   int'(b.idx));
        chk({tag, " out_last"},  int'(out_last_w[k]),  int'(b.last));
        chk({tag, " out_zero"},  int'(out_zero_w[k]),  int'(b.zero));
        chk({tag, " out_total"}, int'(out_total_w[k]), int'(b.total));
      end else if (rst_flag) begin
        chk({tag, " rst out_idx"},   int'(out_idx_w[k]),   0);
        chk({tag, " rst out_last"},  int'(out_last_w[k]),  0);
        chk({tag, " rst out_zero"},  int'(out_zero_w[k]),  0);
        chk({tag, " rst out_total"}, int'(out_total_w[k]), 0);
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic send(input logic [7:0] v);
    in_valid = 1'b1;
    in_vec   = v;
    for (int t = 0; t < 50; t++) begin
      cycle();
      if (acc) break;
    end
    chk("accept", int'(acc), 1);
    in_valid = 1'b0;
    in_vec   = 8'($urandom);
  endtask

  task automatic drain(input bit rnd);
    for (int t = 0; t < 200 && q0.size() > 0; t++) begin
      out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      cycle();
    end
    chk("drain", q0.size(), 0);
    out_ready = 1'b1;
  endtask

  vec_rec_t tbl[9];
  int       nb;

  initial begin
    tbl[0] = '{8'b1001_0110, 4, 1, 7};
    tbl[1] = '{8'hFF,        8, 0, 7};
    tbl[2] = '{8'h00,        0, 0, 0};
    tbl[3] = '{8'h80,        1, 7, 7};
    tbl[4] = '{8'h55,        4, 0, 6};
    tbl[5] = '{8'h03,        2, 0, 1};
    tbl[6] = '{8'h10,        1, 4, 4};
    tbl[7] = '{8'hF0,        4, 4, 7};
    tbl[8] = '{8'h01,        1, 0, 0};

    rst_n = 1'b0; in_valid = 1'b0; in_vec = 8'h00; out_ready = 1'b1;
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Table: first beat, total and beat count per vector.
    for (int r = 0; r < 9; r++) begin
      out_ready = 1'b1;
      send(tbl[r].vec);
      chk($sformatf("tbl%0d first lsb", r), int'(out_idx_w[0]), tbl[r].first_lsb);
      chk($sformatf("tbl%0d first msb", r), int'(out_idx_w[1]), tbl[r].first_msb);
      chk($sformatf("tbl%0d total", r),     int'(out_total_w[0]), tbl[r].total);
      chk($sformatf("tbl%0d zero", r),      int'(out_zero_w[0]), int'(tbl[r].total == 0));
      nb = 1;
      while (!out_last_w[0] && nb < 20) begin
        cycle();
        nb++;
      end
      chk($sformatf("tbl%0d beats", r), nb, (tbl[r].total > 0) ? tbl[r].total : 1);
      cycle();
      chk($sformatf("tbl%0d idle", r), int'(in_ready_w[0] & ~out_valid_w[0]), 1);
    end

    // Random output stalls on 0x55.
    out_ready = 1'b0;
    send(8'h55);
    drain(1'b1);
    cycle();

    // Back-to-back: 0x10 taken on the same edge the idx-1 beat of 0x03 leaves.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_vec    = 8'h03;
    cycle();
    chk("b2b acc A", int'(acc), 1);
    chk("b2b idx0", int'(out_idx_w[0]), 0);
    in_vec = 8'h10;
    cycle();
    chk("b2b no acc", int'(acc), 0);
    chk("b2b idx1", int'(out_idx_w[0]), 1);
    cycle();
    chk("b2b acc B", int'(acc), 1);
    chk("b2b idx4", int'(out_idx_w[0]), 4);
    in_valid = 1'b0;
    cycle();
    chk("b2b idle", int'(out_valid_w[0]), 0);

    // Reset mid-burst.
    send(8'hF0);
    cycle();
    chk("mid idx5", int'(out_idx_w[0]), 5);
    rst_n = 1'b0;
    cycle();
    chk("rst out_valid", int'(out_valid_w[0]), 0);
    chk("rst in_ready",  int'(in_ready_w[0]), 1);
    rst_n = 1'b1;
    send(8'h01);
    chk("post rst idx", int'(out_idx_w[0]), 0);
    chk("post rst last", int'(out_last_w[0]), 1);
    drain(1'b0);

    // Randomised traffic.
    for (int t = 0; t < 600; t++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_vec    = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0;
    drain(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/encod_scan.md
# encod_scan

Sequential 8-to-3 encoder, the inverse of the team's 3-to-8 minterm decoder. It accepts an 8-bit multi-hot vector over a valid/ready handshake and emits the 3-bit index of every set bit, one per accepted output beat, with a last flag and the total set-bit count. It sits between decoded one-hot/multi-hot request lines and index-based consumers such as mux selects and table lookups.

## Interface
- MSB_FIRST, 0, scan order: 0 emits lowest set index first; 1 emits highest first.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can accept a vector this cycle.
- in_vec  in  8  multi-hot input; bit i set means index i is present.
- out_valid  out  1  out_idx/out_last/out_zero/out_total are valid.
- out_ready  in  1  consumer takes the current beat.
- out_idx  out  3  index of the current set bit.
- out_last  out  1  current beat is the final beat for this vector.
- out_zero  out  1  accepted vector was all zeros (single beat, out_idx=0).
- out_total  out  4  popcount of accepted vector (0..8), constant across its beats.

## Operation
- States: IDLE (no vector held) and EMIT (beat on output).
- Reset: state=IDLE, working register rem=8'h00, out_valid=0, out_idx=0, out_last=0, out_zero=0, out_total=0, in_ready=1.
- Accept: in_valid & in_ready at an edge. Load the index of the first bit in scan order into out_idx, clear that bit into rem, set out_total=popcount(in_vec), out_last=(popcount<=1), out_valid=1, state=EMIT.
- Zero vector: accepted normally; emits one beat with out_idx=0, out_zero=1, out_last=1, out_total=0.
- Beat transfer: out_valid & out_ready at an edge. If out_last is 0, load the next index from rem, clear it, and set out_last=(rem has one bit left). If out_last is 1, go to IDLE, or load a new vector when an accept occurs in the same cycle.
- in_ready = (state==IDLE) | (out_valid & out_ready & out_last). This is a combinational path from out_ready. It gives back-to-back vectors with no bubble.
- Stall: while out_valid & ~out_ready, all out_* signals and rem hold stable.
- in_vec is sampled only at acceptance; later changes to it are ignored.
- out_valid never drops without a transfer, except on reset.
- Reset mid-burst discards rem and any pending beat. out_valid=0 on the cycle following the reset edge.

## Timing
- Latency: a vector accepted at edge k presents its first beat from edge k, visible in cycle k+1.
- Throughput: one index per cycle with out_ready held high. A vector with n set bits occupies max(n,1) beats.
- Back-to-back: the last beat of vector A and the acceptance of vector B happen at the same edge. B's first beat follows immediately.
- out_total and out_zero update only at acceptance.

## Structure
- Package encod_pkg holds:
  - state enum (IDLE, EMIT)
  - constants VEC_W=8, IDX_W=3, CNT_W=4
  - a popcount function
- Sub-module encod_prio8: combinational 8:3 priority encoder with the MSB_FIRST parameter. Outputs are idx[2:0], any, and the vector with the chosen bit cleared. It is instantiated once, muxed between in_vec (at accept) and rem (at beat transfer).
- The top holds the state register, rem, the output registers and the handshake logic.

## Test plan
- After reset, check the reset values (in_ready=1, out_valid=0). Then in_vec=8'b1001_0110 with out_ready=1 and MSB_FIRST=0 -> idx 1,2,4,7 on consecutive cycles, out_last only on idx 7, out_total=4 on all beats.
- MSB_FIRST=1, in_vec=8'hFF -> idx 7 down to 0, eight beats, out_last on idx 0, out_total=8.
- in_vec=8'h00 -> one beat: out_zero=1, out_idx=0, out_last=1, out_total=0. Then in_vec=8'h80 -> idx 7, out_zero=0, out_last=1.
- Random out_ready stalls on 8'b0101_0101 -> outputs stable while stalled, sequence 0,2,4,6 with no loss or duplication, in_ready=0 until the last transfer.
- Back-to-back: 8'h03 then 8'h10 with in_valid continuous and out_ready=1 -> beats 0,1,4 in three consecutive cycles, 8'h10 accepted at the same edge as the idx-1 transfer.
- rst_n=0 after the second beat of 8'hF0 -> out_valid=0 next cycle, in_ready=1. A new vector 8'h01 yields idx 0 only.
